// File: rtl/ctrl_pkg.sv
// Shared encodings for the 4-bit MCU instruction sequencer:
// FSM states, opcodes and control-word bit positions.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_INV  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_ADDA = 4'h8;
    localparam logic [3:0] OP_ADDS = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_STA  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam int B_PC_INC  = 0;
    localparam int B_IR_LOAD = 1;
    localparam int B_MUX_IMM = 2;
    localparam int B_ACC_LD  = 3;
    localparam int B_MEM_WR  = 4;
    localparam int B_SHL     = 5;
    localparam int B_SHR     = 6;
    localparam int B_ADDA    = 7;
    localparam int B_ADDS    = 8;
    localparam int B_ADD     = 9;
    localparam int B_SUB     = 10;
    localparam int B_INV     = 11;
    localparam int B_AND     = 12;
    localparam int B_OR      = 13;
    localparam int B_XOR     = 14;

    // Ops whose result lands in ACC one cycle later, needing WRITEBACK
    function automatic logic needs_wb(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SHR);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Control-word decoder: pure function of FSM state and opcode,
// so no input port reaches the control outputs combinationally.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [3:0]  opcode,
    output logic [15:0] control
);

    always_comb begin
        control = '0;
        unique case (state)
            S_FETCH:   control[B_IR_LOAD] = 1'b1;
            S_DECODE:  control[B_PC_INC]  = 1'b1;
            S_WB:      control[B_ACC_LD]  = 1'b1;
            S_EXECUTE: begin
                case (opcode)
                    OP_LDI: begin
                        control[B_MUX_IMM] = 1'b1;
                        control[B_ACC_LD]  = 1'b1;
                    end
                    OP_ADD:  control[B_ADD]    = 1'b1;
                    OP_SUB:  control[B_SUB]    = 1'b1;
                    OP_INV:  control[B_INV]    = 1'b1;
                    OP_AND:  control[B_AND]    = 1'b1;
                    OP_OR:   control[B_OR]     = 1'b1;
                    OP_XOR:  control[B_XOR]    = 1'b1;
                    OP_ADDA: control[B_ADDA]   = 1'b1;
                    OP_ADDS: control[B_ADDS]   = 1'b1;
                    OP_SHL:  control[B_SHL]    = 1'b1;
                    OP_SHR:  control[B_SHR]    = 1'b1;
                    OP_STA:  control[B_MEM_WR] = 1'b1;
                    default: control = '0;
                endcase
            end
            default: control = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute/writeback sequencer driving the ALU control word.
// Holds the FSM, program counter and instruction register.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [7:0]        instr_in,
    input  logic              zero_in,
    output logic [ADDR_W-1:0] pc_out,
    output logic [3:0]        operand_out,
    output logic [15:0]       control,
    output logic              halted
);

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [7:0]        ir, ir_n;
    logic [ADDR_W-1:0] target;

    assign target = ADDR_W'(ir[3:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= 8'h00;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ir    <= ir_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        unique case (state)
            S_IDLE:   if (run) state_n = S_FETCH;
            S_FETCH: begin
                ir_n    = instr_in;
                state_n = S_DECODE;
            end
            S_DECODE: begin
                pc_n    = pc + 1'b1;
                state_n = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_n = S_FETCH;
                if (needs_wb(ir[7:4]))
                    state_n = S_WB;
                else if (ir[7:4] == OP_HLT)
                    state_n = S_HALT;
                else if (ir[7:4] == OP_JMP)
                    pc_n = target;
                else if (ir[7:4] == OP_JZ && zero_in)
                    pc_n = target;
            end
            S_WB:     state_n = S_FETCH;
            S_HALT:   state_n = S_HALT;
            default:  state_n = S_IDLE;
        endcase
    end

    ctrl_decode u_decode (
        .state   (state),
        .opcode  (ir[7:4]),
        .control (control)
    );

    assign pc_out      = pc;
    assign operand_out = ir[3:0];
    assign halted      = (state == S_HALT);

endmodule
